input_buffer: RTL and testbench

INPUT_BUFFER -- requirements
Module: input_buffer

---
 rtl/input_buffer.sv | 126 ++++++++++++
 tb/tb_input_buffer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer.sv
// Frame buffer: collects 256 serial complex samples, then drains them as 32 beats of 8 lanes.
// Define BITREV_ORDER_EN to present lanes in bit-reversed sample order.
//
// state | meaning
// IDLE  | waiting for the first sample of a frame
// FILL  | accepting samples into memory at wr_cnt
// DRAIN | presenting beats to the downstream core, no samples accepted
module input_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        startin,
    input  logic [15:0] realin,
    input  logic [15:0] imagin,
    output logic        readyin,
    output logic [55:0] in0,
    output logic [55:0] in1,
    output logic [55:0] in2,
    output logic [55:0] in3,
    output logic [55:0] in4,
    output logic [55:0] in5,
    output logic [55:0] in6,
    output logic [55:0] in7,
    output logic        outvalid,
    input  logic        outready,
    output logic        framedone,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t      state;
    logic [7:0]  wr_cnt;
    logic [4:0]  rd_cnt;
    logic [15:0] mem_re [256];
    logic [15:0] mem_im [256];
    logic [55:0] lane [8];
    logic        accept;

    assign readyin = !reset && (state != DRAIN);
    assign accept  = startin && readyin;

    assign in0 = lane[0];
    assign in1 = lane[1];
    assign in2 = lane[2];
    assign in3 = lane[3];
    assign in4 = lane[4];
    assign in5 = lane[5];
    assign in6 = lane[6];
    assign in7 = lane[7];

    function automatic logic [27:0] pack_field(input logic [15:0] x);
        return {{10{x[15]}}, x, 2'b00};
    endfunction

    function automatic logic [7:0] beat_addr(input logic [4:0] k, input logic [2:0] j);
        logic [7:0] n;
        logic [7:0] r;
        n = {k, j};
`ifdef BITREV_ORDER_EN
        for (int b = 0; b < 8; b++) r[b] = n[7-b];
`else
        r = n;
`endif
        return r;
    endfunction

    function automatic logic [55:0] lane_word(input logic [7:0] a);
        return {pack_field(mem_im[a]), pack_field(mem_re[a])};
    endfunction

    // Sample memory has no reset; a partial frame is discarded by rewinding wr_cnt.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_re[wr_cnt] <= realin;
            mem_im[wr_cnt] <= imagin;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_cnt    <= 8'd0;
            rd_cnt    <= 5'd0;
            outvalid  <= 1'b0;
            framedone <= 1'b0;
            overflow  <= 1'b0;
            for (int j = 0; j < 8; j++) lane[j] <= 56'd0;
        end else begin
            framedone <= 1'b0;
            overflow  <= startin && (state == DRAIN);
            case (state)
                IDLE, FILL: begin
                    if (accept) begin
                        wr_cnt <= wr_cnt + 8'd1;
                        if (wr_cnt == 8'd255) begin
                            // Beat 0 never contains sample 255, so the old memory view is complete.
                            state    <= DRAIN;
                            outvalid <= 1'b1;
                            rd_cnt   <= 5'd0;
                            for (int j = 0; j < 8; j++)
                                lane[j] <= lane_word(beat_addr(5'd0, 3'(j)));
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                DRAIN: begin
                    if (outready) begin
                        if (rd_cnt == 5'd31) begin
                            state     <= IDLE;
                            outvalid  <= 1'b0;
                            framedone <= 1'b1;
                            rd_cnt    <= 5'd0;
                        end else begin
                            rd_cnt <= rd_cnt + 5'd1;
                            for (int j = 0; j < 8; j++)
                                lane[j] <= lane_word(beat_addr(rd_cnt + 5'd1, 3'(j)));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_buffer.sv
// Scoreboard bench for input_buffer: stimulus pushes expected beats, a monitor pops and compares.
module tb_input_buffer;

    logic        clk = 1'b0;
    logic        reset, startin, outready;
    logic [15:0] realin, imagin;
    logic        readyin, outvalid, framedone, overflow;
    logic [55:0] in0, in1, in2, in3, in4, in5, in6, in7;

    input_buffer dut (
        .clk(clk), .reset(reset), .startin(startin), .realin(realin), .imagin(imagin),
        .readyin(readyin), .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .in5(in5), .in6(in6), .in7(in7), .outvalid(outvalid), .outready(outready),
        .framedone(framedone), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;
    int ov_cnt = 0;
    logic [447:0] sbq[$];
    logic [15:0]  fr_r [256];
    logic [15:0]  fr_i [256];

    function automatic logic [27:0] pack_field(input logic [15:0] x);
        logic [31:0] v;
        v = {{16{x[15]}}, x} * 4;
        return v[27:0];
    endfunction

    function automatic int src_idx(input int k, input int j);
        int n;
        int r;
        n = k * 8 + j;
`ifdef BITREV_ORDER_EN
        r = 0;
        for (int b = 0; b < 8; b++) if (n & (1 << b)) r = r | (1 << (7 - b));
`else
        r = n;
`endif
        return r;
    endfunction

    function automatic logic [447:0] beat_exp(input int k);
        logic [447:0] b;
        int idx;
        for (int j = 0; j < 8; j++) begin
            idx = src_idx(k, j);
            b[j*56 +: 56] = {pack_field(fr_i[idx]), pack_field(fr_r[idx])};
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every presented beat (stalled or accepted) must equal the queue head.
    always @(negedge clk) begin
        logic [447:0] got;
        if (framedone) fd_cnt++;
        if (overflow) ov_cnt++;
        if (outvalid) begin
            got = {in7, in6, in5, in4, in3, in2, in1, in0};
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat actual=%h required=none", got);
            end else begin
                if (got !== sbq[0]) begin
                    errors++;
                    $display("FAIL beat actual=%h required=%h", got, sbq[0]);
                end
                if (outready) void'(sbq.pop_front());
            end
        end
    end

    task automatic load_frame(input int kind);
        for (int n = 0; n < 256; n++) begin
            case (kind)
                0: begin fr_r[n] = 16'(n);          fr_i[n] = 16'(-n);       end
                1: begin fr_r[n] = 16'(n);          fr_i[n] = 16'(n * 37);   end
                2: begin fr_r[n] = 16'(n + 16'h1234); fr_i[n] = 16'(16'hF000 - n); end
                default: begin fr_r[n] = 16'(255 - n); fr_i[n] = 16'(n * 3); end
            endcase
        end
        if (kind == 1) fr_r[0] = 16'h8000;
        if (kind == 2) fr_r[0] = 16'h7FFF;
    endtask

    task automatic push_expected();
        for (int k = 0; k < 32; k++) sbq.push_back(beat_exp(k));
    endtask

    task automatic send_frame(input int nsamp);
        for (int n = 0; n < nsamp; n++) begin
            startin = 1'b1;
            realin  = fr_r[n];
            imagin  = fr_i[n];
            @(posedge clk); #1;
        end
        startin = 1'b0;
    endtask

    task automatic wait_done(input bit tog, output int cyc);
        cyc = 1;
        while (!framedone && cyc < 200) begin
            @(posedge clk); #1;
            if (tog) outready = ~outready;
            cyc++;
        end
        if (!framedone) begin
            errors++;
            checks++;
            $display("FAIL framedone_timeout actual=%0d required=<200", cyc);
        end
    endtask

    initial begin
        int cyc;
        int fd0;
        int ov0;
        logic [27:0] exp_lane_r [8];
        reset = 1'b1; startin = 1'b0; outready = 1'b1; realin = '0; imagin = '0;
        #3;
        chk("reset_readyin", 64'(readyin), 64'd0);
        chk("reset_outvalid", 64'(outvalid), 64'd0);
        chk("reset_framedone", 64'(framedone), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_in0", 64'(in0), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("post_reset_readyin", 64'(readyin), 64'd1);

        // Frame A: ramp, full throughput, latency checks.
        load_frame(0);
        push_expected();
        send_frame(256);
        chk("a_outvalid_first", 64'(outvalid), 64'd1);
        chk("a_readyin_drain", 64'(readyin), 64'd0);
`ifdef BITREV_ORDER_EN
        chk("a_in3_real", 64'(in3[27:0]), 64'h0000300);
        chk("a_in3_imag", 64'(in3[55:28]), 64'hFFFFD00);
        exp_lane_r = '{28'd0, 28'd512, 28'd256, 28'd768, 28'd128, 28'd640, 28'd384, 28'd896};
        chk("a_bitrev_in0", 64'(in0[27:0]), 64'(exp_lane_r[0]));
        chk("a_bitrev_in1", 64'(in1[27:0]), 64'(exp_lane_r[1]));
        chk("a_bitrev_in2", 64'(in2[27:0]), 64'(exp_lane_r[2]));
        chk("a_bitrev_in7", 64'(in7[27:0]), 64'(exp_lane_r[7]));
`else
        chk("a_in3_real", 64'(in3[27:0]), 64'h000000C);
        chk("a_in3_imag", 64'(in3[55:28]), 64'hFFFFFF4);
`endif
        wait_done(1'b0, cyc);
        chk("a_framedone_latency", 64'(cyc), 64'd33);
        chk("a_readyin_after", 64'(readyin), 64'd1);
        chk("a_outvalid_after", 64'(outvalid), 64'd0);
        @(posedge clk); #1;
        chk("a_framedone_pulse", 64'(framedone), 64'd0);
        chk("a_queue_empty", 64'(sbq.size()), 64'd0);

        // Frame B: outready toggling, 16'h8000 packing.
        load_frame(1);
        push_expected();
        fd0 = fd_cnt;
        send_frame(256);
        chk("b_in0_real_min", 64'(in0[27:0]), 64'hFFE0000);
        wait_done(1'b1, cyc);
        outready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("b_framedone_once", 64'(fd_cnt - fd0), 64'd1);
        chk("b_queue_empty", 64'(sbq.size()), 64'd0);

        // Frame C: drain stalled while startin is held, 16'h7FFF packing.
        load_frame(2);
        push_expected();
        outready = 1'b0;
        send_frame(256);
        chk("c_in0_real_max", 64'(in0[27:0]), 64'h001FFFC);
        ov0 = ov_cnt;
        for (int i = 0; i < 5; i++) begin
            startin = 1'b1;
            realin  = 16'hDEAD;
            imagin  = 16'hBEEF;
            #1 chk("c_readyin_low", 64'(readyin), 64'd0);
            @(posedge clk); #1;
        end
        startin = 1'b0;
        @(posedge clk); #1;
        chk("c_overflow_count", 64'(ov_cnt - ov0), 64'd5);
        outready = 1'b1;
        wait_done(1'b0, cyc);
        @(posedge clk); #1;
        chk("c_queue_empty", 64'(sbq.size()), 64'd0);

        // Partial frame discarded by reset, then a fresh frame.
        load_frame(0);
        send_frame(100);
        #2 reset = 1'b1;
        #1;
        chk("r_readyin_in_reset", 64'(readyin), 64'd0);
        chk("r_in0_cleared", 64'(in0), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        load_frame(3);
        push_expected();
        send_frame(256);
        chk("r_outvalid_first", 64'(outvalid), 64'd1);
        wait_done(1'b0, cyc);
        chk("r_framedone_latency", 64'(cyc), 64'd33);
        @(posedge clk); #1;
        chk("r_queue_empty", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
